// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level constants.
// The receiver on the same link imports this package as well.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO in front of the transmitter. A push while full and a
// pop while empty are ignored; a push and a pop in the same cycle leave the
// occupancy unchanged and keep byte order.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO.
// Handshake: a byte on tx_byte is taken on the rising edge where
// data_valid && ready; ready is low only while the FIFO is full, and the
// producer must hold tx_byte/data_valid until that edge. tx_byte is ignored
// whenever data_valid is low.
// Line outputs are registered from next-state values, so the start bit is on
// the line in the cycle right after IDLE pops a byte.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       data_valid,
  output logic       ready,
  output logic       serial_stream,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg, shift_n;
  logic             serial_n, active_n, done_n;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_valid),
    .din   (tx_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_full;

  // State, counters, shift register and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      serial_stream <= IDLE_LEVEL;
      tx_active     <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      state         <= state_n;
      clk_cnt       <= clk_cnt_n;
      bit_idx       <= bit_idx_n;
      shift_reg     <= shift_n;
      serial_stream <= serial_n;
      tx_active     <= active_n;
      tx_done       <= done_n;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    done_n    = 1'b0;
    fifo_pop  = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_n   = fifo_dout;
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (bit_idx == BIT_LAST) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    serial_n = IDLE_LEVEL;
    active_n = 1'b0;
    case (state_n)
      START: begin
        serial_n = START_BIT;
        active_n = 1'b1;
      end
      DATA: begin
        serial_n = shift_n[bit_idx_n];
        active_n = 1'b1;
      end
      STOP: begin
        serial_n = STOP_BIT;
        active_n = 1'b1;
      end
      default: begin
        serial_n = IDLE_LEVEL;
        active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. A cycle-level model
// derives every expected line level, tx_active, tx_done and ready from the
// accepted-byte queue and the frame timing rules.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] tx_byte;
  logic       data_valid;
  logic       ready;
  logic       serial_stream;
  logic       tx_active;
  logic       tx_done;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_byte       (tx_byte),
    .data_valid    (data_valid),
    .ready         (ready),
    .serial_stream (serial_stream),
    .tx_active     (tx_active),
    .tx_done       (tx_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         acc_c[$];
  int         fifo_cnt = 0;
  bit         busy = 0;
  int         start_c = 0;
  int         next_ok = 0;
  logic [7:0] cur = 8'h00;
  int         k;
  int         bi;
  logic       e_ser, e_act, e_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Record accepted bytes with the edge number they were taken on.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && data_valid && ready) begin
      exp_q.push_back(tx_byte);
      acc_c.push_back(cyc);
      fifo_cnt = fifo_cnt + 1;
    end
  end

  // Reference model: a frame starts on the first cycle that is at least one
  // edge after acceptance and at least 10*CPB+1 cycles after the previous
  // start; bits are CPB cycles each, LSB first; done follows the stop bit.
  always @(negedge clk) begin
    if (rst) begin
      busy     = 0;
      fifo_cnt = 0;
      next_ok  = 0;
      exp_q.delete();
      acc_c.delete();
    end else begin
      e_ser  = 1'b1;
      e_act  = 1'b0;
      e_done = 1'b0;
      if (busy) begin
        k = cyc - start_c;
        if (k < FRAME) begin
          e_act = 1'b1;
          bi    = k / CPB;
          if (bi == 0)      e_ser = 1'b0;
          else if (bi <= 8) e_ser = cur[bi-1];
          else              e_ser = 1'b1;
        end else begin
          e_done  = 1'b1;
          busy    = 0;
          next_ok = start_c + FRAME + 1;
        end
      end
      if (!busy && exp_q.size() > 0 && cyc >= acc_c[0] + 1 && cyc >= next_ok) begin
        busy     = 1;
        start_c  = cyc;
        cur      = exp_q.pop_front();
        void'(acc_c.pop_front());
        fifo_cnt = fifo_cnt - 1;
        e_ser    = 1'b0;
        e_act    = 1'b1;
      end
      check_eq("serial_stream", 32'(serial_stream), 32'(e_ser));
      check_eq("tx_active", 32'(tx_active), 32'(e_act));
      check_eq("tx_done", 32'(tx_done), 32'(e_done));
      check_eq("ready", 32'(ready), 32'(fifo_cnt < DEPTH));
    end
  end

  // ---------------- driver tasks (call at a negedge) ----------------
  task automatic push_byte(input logic [7:0] b);
    int n;
    n          = 0;
    tx_byte    = b;
    data_valid = 1'b1;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_timeout", 32'(n >= 500), 32'd0);
    @(negedge clk);
    data_valid = 1'b0;
    tx_byte    = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(n >= 3000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    tx_byte    = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_serial", 32'(serial_stream), 32'd1);
    check_eq("rst_active", 32'(tx_active), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte.
    push_byte(8'hA5);
    wait_idle();

    // Back-to-back bytes on consecutive cycles.
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    wait_idle();

    // Backpressure: six bytes offered continuously.
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
    wait_idle();

    // Push landing on the same edge as the pop of the previous byte.
    push_byte(8'hC3);
    push_byte(8'h3C);
    wait_idle();

    // Random bytes with random gaps and bursts.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(5, 60)) @(negedge clk);
      push_byte(8'($urandom_range(0, 255)));
    end
    wait_idle();

    // Reset in the middle of a data bit, with bytes still queued.
    push_byte(8'h00);
    push_byte(8'h81);
    push_byte(8'h42);
    repeat (12) @(negedge clk);
    check_eq("pre_rst_serial", 32'(serial_stream), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_serial", 32'(serial_stream), 32'd1);
    check_eq("midrst_active", 32'(tx_active), 32'd0);
    check_eq("midrst_done", 32'(tx_done), 32'd0);
    check_eq("midrst_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Model expects an idle line here: discarded bytes must never appear.
    repeat (60) @(negedge clk);

    // Transmitter still works after the abort.
    push_byte(8'h96);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
